// File: rtl/ascon_state_serializer.sv
// ascon_state_serializer: captures a 320-bit ASCON state in one cycle and
// drains a window of its 64-bit words (x0..x4) over a valid/ready stream.
// Word k of the state is x_k, with x0 held in the most significant bits.
module ascon_state_serializer #(
  parameter int WORD_W   = 64,
  parameter int NB_WORDS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic [WORD_W*NB_WORDS-1:0] state_i,
  input  logic [2:0]                 first_i,
  input  logic [2:0]                 count_i,
  output logic                       ready_o,
  output logic [WORD_W-1:0]          word_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic [2:0]                 index_o,
  output logic                       done_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } fsm_t;

  fsm_t                       fsm_q, fsm_d;
  logic [WORD_W*NB_WORDS-1:0] state_q, state_d;
  logic [2:0]                 idx_q, idx_d;
  logic [2:0]                 rem_q, rem_d;
  logic                       done_q, done_d;

  logic [2:0]                 first_san;
  logic [2:0]                 count_san;
  logic [WORD_W-1:0]          words [NB_WORDS];

  // Split the captured state into its individual words, x0 at the top.
  generate
    for (genvar gi = 0; gi < NB_WORDS; gi++) begin : g_words
      assign words[gi] = state_q[(NB_WORDS-1-gi)*WORD_W +: WORD_W];
    end
  endgenerate

  // Out-of-range first index restarts at x0; oversized counts cover the whole state.
  always_comb begin
    first_san = (first_i >= 3'(NB_WORDS)) ? 3'd0 : first_i;
    count_san = (count_i > 3'(NB_WORDS))  ? 3'(NB_WORDS) : count_i;
  end

  // Next-state logic: capture in IDLE, advance the window on each accepted word.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (load_i) begin
          state_d = state_i;
          idx_d   = first_san;
          rem_d   = count_san;
          if (count_san == 3'd0) begin
            // Empty window: report completion without emitting anything.
            done_d = 1'b1;
          end else begin
            fsm_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        // valid_o is always high here, so ready_i alone marks a transfer.
        if (ready_i) begin
          if (rem_q == 3'd1) begin
            fsm_d  = S_IDLE;
            rem_d  = 3'd0;
            done_d = 1'b1;
          end else begin
            rem_d = rem_q - 3'd1;
            idx_d = (idx_q == 3'(NB_WORDS-1)) ? 3'd0 : idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      idx_q   <= 3'd0;
      rem_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded straight from registers so reset clears them at once.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < NB_WORDS; k++) begin
      if (idx_q == 3'(k)) begin
        word_o = words[k];
      end
    end
    ready_o = (fsm_q == S_IDLE);
    valid_o = (fsm_q == S_SEND);
    last_o  = (fsm_q == S_SEND) && (rem_q == 3'd1);
    index_o = idx_q;
    done_o  = done_q;
  end

endmodule

// File: tb/tb_ascon_state_serializer.sv
// Testbench for ascon_state_serializer: directed windows with a scoreboard
// queue of expected words, popped by a monitor on every accepted transfer.
module tb_ascon_state_serializer;

  logic         clk;
  logic         reset;
  logic         load_i;
  logic [319:0] state_i;
  logic [2:0]   first_i;
  logic [2:0]   count_i;
  logic         ready_o;
  logic [63:0]  word_o;
  logic         valid_o;
  logic         ready_i;
  logic         last_o;
  logic [2:0]   index_o;
  logic         done_o;

  typedef struct {
    logic [63:0] w;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] xs [5];
  logic [63:0] alt [5];

  ascon_state_serializer #(.WORD_W(64), .NB_WORDS(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_i),
    .state_i (state_i),
    .first_i (first_i),
    .count_i (count_i),
    .ready_o (ready_o),
    .word_o  (word_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o),
    .index_o (index_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] pack(input logic [63:0] a [5]);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  // Monitor: pop and compare on every accepted word, and check stall stability.
  logic        stall_prev = 1'b0;
  logic [63:0] held_w;
  logic [2:0]  held_idx;
  logic        held_last;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_word",  word_o, held_w);
        check("stall_index", 64'(index_o), 64'(held_idx));
        check("stall_last",  64'(last_o), 64'(held_last));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(valid_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("xfer idx=%0d word=%h last=%0d", index_o, word_o, last_o);
          check("word",  word_o, e.w);
          check("index", 64'(index_o), 64'(e.idx));
          check("last",  64'(last_o), 64'(e.last));
        end
      end
      stall_prev = valid_o && !ready_i;
      held_w     = word_o;
      held_idx   = index_o;
      held_last  = last_o;
    end
  end

  // mode: 0 = ready_i high, 1 = ready_i toggles starting low, 2 = ready high plus
  // load_i pulses mid-window and on the completing cycle.
  task automatic run_window(input string nm, input logic [2:0] fi, input logic [2:0] ci,
                            input int ef, input int ec, input int mode);
    int  cyc;
    bit  got_done;
    for (int i = 0; i < ec; i++) begin
      exp_t e;
      e.w    = xs[(ef + i) % 5];
      e.idx  = 3'((ef + i) % 5);
      e.last = (i == ec - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    check({nm, "_ready_before_load"}, 64'(ready_o), 64'd1);
    load_i  = 1'b1;
    state_i = pack(xs);
    first_i = fi;
    count_i = ci;
    ready_i = (mode != 1);
    @(posedge clk); #1;
    load_i  = 1'b0;
    state_i = ~pack(xs);
    check({nm, "_first_valid"}, 64'(valid_o), 64'(ec != 0));
    cyc = 0;
    got_done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      load_i = 1'b0;
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      if (valid_o) begin
        check({nm, "_ready_in_send"}, 64'(ready_o), 64'd0);
        cyc++;
      end
      ready_i = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (mode == 2 && (cyc == 2 || cyc == ec)) begin
        load_i  = 1'b1;
        state_i = pack(alt);
        first_i = 3'd1;
        count_i = 3'd1;
      end
      @(posedge clk); #1;
    end
    check({nm, "_done_seen"}, 64'(got_done), 64'd1);
    check({nm, "_send_cycles"}, 64'(cyc), 64'(mode == 1 ? 2 * ec : ec));
    check({nm, "_ready_at_done"}, 64'(ready_o), 64'd1);
    check({nm, "_valid_at_done"}, 64'(valid_o), 64'd0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    check({nm, "_done_one_pulse"}, 64'(done_o), 64'd0);
    check({nm, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    load_i  = 1'b0;
    state_i = '0;
    first_i = 3'd0;
    count_i = 3'd0;
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) alt[k] = 64'h5555_5555_5555_5550 + 64'(k);
    #2;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_last",  64'(last_o),  64'd0);
    check("rst_done",  64'(done_o),  64'd0);
    check("rst_word",  word_o, 64'd0);
    check("rst_index", 64'(index_o), 64'd0);
    #10 reset = 1'b0;

    // Full drain: x_k = k.
    xs[0] = 64'd0; xs[1] = 64'd1; xs[2] = 64'd2; xs[3] = 64'd3; xs[4] = 64'd4;
    run_window("full", 3'd0, 3'd5, 0, 5, 0);

    // Tag window x3/x4.
    xs[0] = 64'h1010_1010_1010_1010; xs[1] = 64'h2020_2020_2020_2020;
    xs[2] = 64'h3030_3030_3030_3030;
    xs[3] = 64'hDEAD_BEEF_0000_0003; xs[4] = 64'hCAFE_F00D_0000_0004;
    run_window("tag", 3'd3, 3'd2, 3, 2, 0);

    // Wrap 4 -> 0 -> 1 with ready_i toggling.
    xs[0] = 64'hA000_0000_0000_00A0; xs[1] = 64'hA100_0000_0000_00A1;
    xs[2] = 64'hA200_0000_0000_00A2; xs[3] = 64'hA300_0000_0000_00A3;
    xs[4] = 64'hA400_0000_0000_00A4;
    run_window("wrap_bp", 3'd4, 3'd3, 4, 3, 1);

    // Empty window.
    run_window("count0", 3'd2, 3'd0, 2, 0, 0);

    // Out-of-range first/count sanitised to first=0, count=5.
    xs[0] = 64'h0123_4567_89AB_CDEF; xs[1] = 64'hFEDC_BA98_7654_3210;
    xs[2] = 64'h0F0F_0F0F_F0F0_F0F0; xs[3] = 64'h8000_0000_0000_0001;
    xs[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_window("clamp", 3'd6, 3'd7, 0, 5, 0);

    // load_i during SEND and on the completing cycle is ignored.
    xs[0] = 64'hB0B0_0000_0000_0000; xs[1] = 64'hB1B1_0000_0000_0001;
    xs[2] = 64'hB2B2_0000_0000_0002; xs[3] = 64'hB3B3_0000_0000_0003;
    xs[4] = 64'hB4B4_0000_0000_0004;
    run_window("midload", 3'd0, 3'd5, 0, 5, 2);
    // A fresh load is accepted once back in IDLE.
    run_window("after_midload", 3'd2, 3'd1, 2, 1, 0);

    // Asynchronous reset while word 2 of 5 is presented.
    xs[0] = 64'hC0; xs[1] = 64'hC1; xs[2] = 64'hC2; xs[3] = 64'hC3; xs[4] = 64'hC4;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.w = xs[i]; e.idx = 3'(i); e.last = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    load_i  = 1'b1;
    state_i = pack(xs);
    first_i = 3'd0;
    count_i = 3'd5;
    ready_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_index_before", 64'(index_o), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("rstmid_valid", 64'(valid_o), 64'd0);
    check("rstmid_word",  word_o, 64'd0);
    check("rstmid_ready", 64'(ready_o), 64'd1);
    check("rstmid_index", 64'(index_o), 64'd0);
    check("rstmid_done",  64'(done_o), 64'd0);
    #13 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_done", 64'(done_o), 64'd0);
      check("rstmid_idle", 64'(valid_o), 64'd0);
    end
    check("rstmid_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_state_serializer.md
Name: ascon_state_serializer

Overview:
- Drains a 320-bit ASCON state into 64-bit words over a valid/ready stream.
- Sits at the output end of the permutation datapath: it captures the latched permutation state in one cycle, then emits a selected window of state words (x0..x4), e.g. rate output or tag words x3/x4, to the downstream consumer.
- The pipeline above can start the next permutation while words drain.

Parameters:
- WORD_W, 64, width of one state word (x0..x4).
- NB_WORDS, 5, number of words in the state.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_i  in  1  capture request; honoured only when ready_o=1.
- state_i  in  320 (type_state)  state to capture; word k = x_k, with x0 in the most significant 64 bits.
- first_i  in  3  index of the first word to emit (0..4).
- count_i  in  3  number of words to emit (0..5).
- ready_o  out  1  block is idle and able to accept load_i.
- word_o  out  64  current output word, x_index.
- valid_o  out  1  word_o is valid.
- ready_i  in  1  consumer accepts word_o when valid_o=1.
- last_o  out  1  current word is the final word of the window.
- index_o  out  3  index of the word currently presented.
- done_o  out  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (asynchronous, active-high, effective immediately and mid-operation):
  - State register = 0, FSM = IDLE, idx = 0, remaining = 0.
  - Outputs: ready_o=1, valid_o=0, last_o=0, done_o=0, word_o=0, index_o=0.
- FSM has two states.
  - IDLE: ready_o=1, valid_o=0.
  - SEND: ready_o=0, valid_o=1.
- Input sanitising, applied at capture:
  - first_i values 5..7 are treated as 0.
  - count_i values 6..7 are clamped to 5.
- IDLE with load_i=1 at edge N:
  - Capture state_i, set idx=first (sanitised), remaining=count (clamped).
  - If count=0: stay IDLE, pulse done_o in cycle N+1, emit no word.
  - Otherwise: enter SEND; valid_o=1 from cycle N+1. Capture-to-first-word latency is 1 cycle.
- SEND outputs:
  - word_o = captured x_idx; index_o = idx.
  - last_o = (remaining==1).
- Transfer occurs on any edge where valid_o=1 and ready_i=1.
  - If remaining>1: idx advances by 1, wrapping 4 -> 0; remaining decrements.
  - If remaining==1: return to IDLE, valid_o drops at the next cycle, done_o pulses for exactly one cycle coincident with ready_o returning to 1.
- Backpressure:
  - While valid_o=1 and ready_i=0, word_o, index_o and last_o hold stable.
  - valid_o never deasserts until the transfer completes.
- load_i while in SEND: ignored; state_i, first_i and count_i are not sampled and the captured state is unaffected.
- Load and completion in the same cycle: load_i is not accepted, because ready_o=0 in that cycle. It is accepted at the earliest in the following cycle, when ready_o=1.
- Throughput: one word per cycle with ready_i held high. A window of n words takes n cycles in SEND. Back-to-back windows are separated by one IDLE cycle.
- word_o in IDLE: shows x_idx of the last captured state. Not meaningful; consumers qualify it with valid_o.
- Word order: strictly increasing index modulo 5 from first_i. A window with count=5 visits every word exactly once.

Test Plan:
- Reset then full drain:
  - Stimulus: x0..x4 = 64'h0000_0000_0000_0000 + k (k = 0..4), first=0, count=5, ready_i=1.
  - Response: valid_o for 5 consecutive cycles starting 1 cycle after load; word_o = 0,1,2,3,4; last_o only on word 4; done_o one pulse; ready_o=1 afterward.
- Tag window:
  - Stimulus: first=3, count=2 with x3=64'hDEAD_BEEF_0000_0003, x4=64'hCAFE_F00D_0000_0004.
  - Response: exactly those two words in order, index_o=3 then 4, last_o on the second.
- Wrap and backpressure:
  - Stimulus: first=4, count=3, ready_i toggled 0/1 each cycle.
  - Response: indices 4,0,1; each word held stable while ready_i=0; total 6 SEND cycles; one done_o pulse.
- Edge values:
  - Stimulus: count=0 -> Response: no valid_o, done_o pulse next cycle.
  - Stimulus: count=7, first=6 -> Response: treated as first=0, count=5.
- Load during SEND:
  - Stimulus: pulse load_i with a different state_i mid-window.
  - Response: the window continues with the originally captured words; the next load is accepted only once ready_o=1.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between edges during word 2 of 5.
  - Response: valid_o=0, word_o=0 and ready_o=1 immediately, with no done_o pulse.
